// File: rtl/irs_read_pkg.sv
// IRS read-side shared types and constants.
// Used by the event block scheduler and its slot ring.
package irs_read_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int BLK_W     = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIST,
    S_LOCK,
    S_COMMIT
  } ev_state_t;

  typedef enum logic {
    F_IDLE,
    F_REQ
  } fr_state_t;

endpackage

// File: rtl/irs_event_block_scheduler_ring.sv
// Slot ring for locked blocks: memory plus alloc/commit/rd/fr.
// Pointers carry one wrap bit so full and empty are distinct.
module irs_block_ring
  import irs_read_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      alloc_en,
  input  logic [4:0]                alloc_len,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_slot,
  input  logic [BLK_W-1:0]          wr_block,
  input  logic                      wr_last,
  input  logic                      commit_en,
  input  logic                      rd_ready_i,
  input  logic                      fr_adv,
  output logic [$clog2(DEPTH):0]    alloc_ptr,
  output logic [$clog2(DEPTH)+1:0]  free_slots,
  output logic [$clog2(DEPTH):0]    held,
  output logic [BLK_W-1:0]          fr_block,
  output logic [BLK_W-1:0]          rd_block_o,
  output logic                      rd_last_o,
  output logic                      rd_valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] alloc;
  logic [PW-1:0] commit;
  logic [PW-1:0] rd;
  logic [PW-1:0] fr;
  logic [PW-1:0] rd_n;
  logic [PW-1:0] commit_n;
  logic          xfer;
  logic          valid_n;
  logic [BLK_W:0] mem [DEPTH];
  logic [BLK_W:0] rd_slot;

  assign xfer      = rd_valid_o & rd_ready_i;
  assign rd_n      = rd + PW'(xfer);
  assign commit_n  = commit_en ? alloc : commit;
  assign valid_n   = (rd_n != commit_n);
  assign rd_slot   = mem[rd_n[AW-1:0]];

  assign alloc_ptr  = alloc;
  assign held       = rd - fr;
  assign free_slots = (PW+1)'(DEPTH) - {1'b0, alloc - fr};
  assign fr_block   = mem[fr[AW-1:0]][BLK_W-1:0];

  // Pointer state; fr uses its pre-update value for free space.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc  <= '0;
      commit <= '0;
      rd     <= '0;
      fr     <= '0;
    end else begin
      if (alloc_en)
        alloc <= alloc + PW'(alloc_len);
      if (commit_en)
        commit <= alloc;
      rd <= rd_n;
      if (fr_adv)
        fr <= fr + PW'(1);
    end
  end

  // Slot memory: {last, block}.
  always_ff @(posedge clk_i) begin
    if (wr_en)
      mem[wr_slot] <= {wr_last, wr_block};
  end

  // Registered readout head, reloaded every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_o <= 1'b0;
      rd_block_o <= '0;
      rd_last_o  <= 1'b0;
    end else begin
      rd_valid_o <= valid_n;
      rd_block_o <= valid_n ? rd_slot[BLK_W-1:0] : '0;
      rd_last_o  <= valid_n & rd_slot[BLK_W];
    end
  end

endmodule

// File: rtl/irs_event_block_scheduler.sv
// IRS event block scheduler: history walk, lock, readout, free.
// IRS_EVENT_SCHED_STATS_EN enables the saturating event/drop counters.
module irs_event_block_scheduler
  import irs_read_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trig_i,
  input  logic [4:0]        trig_len_i,
  output logic [BLK_W-1:0]  hist_offset_o,
  output logic              hist_req_o,
  input  logic              hist_ack_i,
  input  logic [BLK_W-1:0]  hist_block_i,
  output logic [BLK_W-1:0]  lock_block_o,
  output logic              lock_req_o,
  input  logic              lock_ack_i,
  output logic [BLK_W-1:0]  free_block_o,
  output logic              free_req_o,
  input  logic              free_ack_i,
  output logic [BLK_W-1:0]  rd_block_o,
  output logic              rd_last_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  input  logic              rd_done_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [15:0]       event_count_o,
  output logic [15:0]       dropped_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  ev_state_t     state;
  fr_state_t     fstate;
  logic [PW-1:0] base;
  logic [4:0]    len_q;
  logic [4:0]    idx;
  logic [5:0]    pend;

  logic [PW-1:0] alloc_ptr;
  logic [PW:0]   free_slots;
  logic [PW-1:0] held;
  logic [BLK_W-1:0] fr_block;
  logic [PW-1:0] slot;

  logic take;
  logic trig_ok;
  logic alloc_en;
  logic wr_en;
  logic commit_en;
  logic done_ok;
  logic fr_adv;

  assign take      = (state == S_IDLE) && trig_i;
  assign trig_ok   = (trig_len_i != 5'd0) &&
                     (7'(trig_len_i) <= 7'(free_slots));
  assign alloc_en  = take && trig_ok;
  assign wr_en     = (state == S_LOCK) && lock_ack_i;
  assign commit_en = (state == S_COMMIT);
  assign slot      = base + PW'(len_q) - PW'(idx) - PW'(1);
  assign done_ok   = rd_done_i && (7'(pend) < 7'(held));
  assign fr_adv    = (fstate == F_REQ) && free_ack_i;

  irs_block_ring #(
    .DEPTH(DEPTH)
  ) u_ring (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .alloc_en   (alloc_en),
    .alloc_len  (trig_len_i),
    .wr_en      (wr_en),
    .wr_slot    (slot[AW-1:0]),
    .wr_block   (lock_block_o),
    .wr_last    (idx == 5'd0),
    .commit_en  (commit_en),
    .rd_ready_i (rd_ready_i),
    .fr_adv     (fr_adv),
    .alloc_ptr  (alloc_ptr),
    .free_slots (free_slots),
    .held       (held),
    .fr_block   (fr_block),
    .rd_block_o (rd_block_o),
    .rd_last_o  (rd_last_o),
    .rd_valid_o (rd_valid_o)
  );

  // Event FSM: newest-first lookup and lock, then publish.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      hist_req_o    <= 1'b0;
      hist_offset_o <= '0;
      lock_req_o    <= 1'b0;
      lock_block_o  <= '0;
      busy_o        <= 1'b0;
      base          <= '0;
      len_q         <= '0;
      idx           <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (alloc_en) begin
            base          <= alloc_ptr;
            len_q         <= trig_len_i;
            idx           <= '0;
            hist_offset_o <= '0;
            hist_req_o    <= 1'b1;
            busy_o        <= 1'b1;
            state         <= S_HIST;
          end
        end
        S_HIST: begin
          if (hist_ack_i) begin
            hist_req_o   <= 1'b0;
            lock_block_o <= hist_block_i;
            lock_req_o   <= 1'b1;
            state        <= S_LOCK;
          end
        end
        S_LOCK: begin
          if (lock_ack_i) begin
            lock_req_o <= 1'b0;
            if (idx == len_q - 5'd1) begin
              state <= S_COMMIT;
            end else begin
              idx           <= idx + 5'd1;
              hist_offset_o <= BLK_W'(idx + 5'd1);
              hist_req_o    <= 1'b1;
              state         <= S_HIST;
            end
          end
        end
        S_COMMIT: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Free FSM and pending-done count; bad dones raise err.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fstate       <= F_IDLE;
      free_req_o   <= 1'b0;
      free_block_o <= '0;
      pend         <= '0;
      err_o        <= 1'b0;
    end else begin
      if (rd_done_i && !done_ok)
        err_o <= 1'b1;
      if (done_ok && !fr_adv)
        pend <= pend + 6'd1;
      else if (fr_adv && !done_ok)
        pend <= pend - 6'd1;
      unique case (fstate)
        F_IDLE: begin
          if (pend != 6'd0 || done_ok) begin
            free_block_o <= fr_block;
            free_req_o   <= 1'b1;
            fstate       <= F_REQ;
          end
        end
        F_REQ: begin
          if (free_ack_i) begin
            free_req_o <= 1'b0;
            fstate     <= F_IDLE;
          end
        end
      endcase
    end
  end

`ifdef IRS_EVENT_SCHED_STATS_EN
  logic [15:0] ev_cnt;
  logic [15:0] dr_cnt;
  logic        dr_inc;

  assign dr_inc = take && !trig_ok;

  // Saturating statistics counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ev_cnt <= '0;
      dr_cnt <= '0;
    end else begin
      if (commit_en && ev_cnt != 16'hFFFF)
        ev_cnt <= ev_cnt + 16'd1;
      if (dr_inc && dr_cnt != 16'hFFFF)
        dr_cnt <= dr_cnt + 16'd1;
    end
  end

  assign event_count_o   = ev_cnt;
  assign dropped_count_o = dr_cnt;
`else
  assign event_count_o   = '0;
  assign dropped_count_o = '0;
`endif

endmodule

// File: doc/irs_event_block_scheduler.md
# irs_event_block_scheduler

Read-side counterpart of the IRS write path: on a trigger it walks the write history buffer newest-to-oldest, locks each block with the IRS manager, and presents the locked blocks oldest-first to the readout engine. When the readout engine reports a block done, the scheduler frees that block back to the manager. It is the initiator on the history, lock and free handshakes; the IRS write top is the responder.

## Interface
- DEPTH, 16, ring slots for locked blocks; power of two, at most 32
- clk_i  in  1  system clock; the only clock
- rst_i  in  1  reset, synchronous, active-high
- trig_i  in  1  trigger pulse; sampled only in IDLE
- trig_len_i  in  5  blocks per event; legal range 1..DEPTH
- hist_offset_o  out  9  blocks back from newest written block
- hist_req_o / hist_ack_i  out/in  1  history lookup handshake
- hist_block_i  in  9  looked-up block; valid on the hist_ack_i cycle
- lock_block_o  out  9  block to lock
- lock_req_o / lock_ack_i  out/in  1  lock handshake
- free_block_o  out  9  block to free
- free_req_o / free_ack_i  out/in  1  free handshake
- rd_block_o  out  9  next block to read out
- rd_last_o  out  1  rd_block_o is the last block of its event
- rd_valid_o / rd_ready_i  out/in  1  readout stream; transfer when both are high
- rd_done_i  in  1  pulse: oldest read-but-unfreed block is finished
- busy_o  out  1  state is not IDLE
- err_o  out  1  sticky: rd_done_i received with nothing outstanding
- event_count_o, dropped_count_o  out  16  statistics; see Configuration

## Operation
- Request/acknowledge handshakes:
  - Each req is a level and holds until its ack.
  - Each ack is a one-cycle pulse.
  - The req deasserts in the cycle after the ack.
  - The address/offset output is stable while req is high.
- Ring pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH:
  - alloc: reserved up to here.
  - commit: visible to readout up to here.
  - rd: next slot to present to readout.
  - fr: next slot to free.
- Free space is DEPTH − (alloc − fr).
- Event FSM has four states: IDLE, HIST, LOCK, COMMIT.
  - IDLE, trig_i=1:
    - If trig_len_i is 0 or exceeds free space: drop the event, increment dropped count, stay in IDLE.
    - Otherwise: base←alloc, alloc←alloc+len, i←0, go to HIST.
  - HIST:
    - hist_req_o=1 with hist_offset_o=i.
    - On ack: latch hist_block_i, go to LOCK.
  - LOCK:
    - lock_req_o=1 with the latched block.
    - On ack: write the block to slot base+len−1−i; the slot's last flag is set when i=0.
    - If i=len−1 go to COMMIT, else i←i+1 and go to HIST.
  - COMMIT: one cycle; commit←alloc, increment event count, go to IDLE.
- The first lock pauses sampling, so lookups at offsets 1..len−1 are stable.
- Readout:
  - rd_valid_o = (rd≠commit).
  - rd_block_o and rd_last_o come from slot rd.
  - Transfer advances rd.
  - Partially built events are never visible.
- Free path:
  - A 6-bit pend counter increments on each rd_done_i; rd_done_i is legal only when pend < (rd−fr).
  - An illegal rd_done_i is ignored and sets err_o.
  - Free FSM states are F_IDLE and F_REQ.
  - F_IDLE with pend≠0: go to F_REQ with free_block_o = slot fr.
  - F_REQ on free_ack_i: fr←fr+1; pend decrements, unless a new rd_done_i arrives in the same cycle, in which case pend is unchanged.
- Event and free FSMs run concurrently. fr advancing and a trigger in the same cycle use the pre-update fr.

## Timing
- Reset values:
  - All req outputs 0; all address/offset outputs 0.
  - rd_valid_o, rd_last_o, busy_o, err_o 0; counters 0.
  - Pointers 0, pend 0, both FSMs idle.
- rst_i mid-operation abandons all locks. The manager shares rst_i and clears as well.
- All outputs are registered.
- hist_req_o rises 1 cycle after the trig_i sample.
- lock_req_o rises 1 cycle after hist_ack_i.
- The next hist_req_o rises 1 cycle after lock_ack_i.
- Per block: 2 cycles plus both ack delays.
- rd_valid_o rises 1 cycle after COMMIT.
- free_req_o rises 1 cycle after rd_done_i when the free FSM is idle.
- Back-to-back rd_transfer: one per cycle.

## Configuration
- IRS_EVENT_SCHED_STATS_EN:
  - Defined: event_count_o and dropped_count_o are 16-bit saturating counters.
  - Undefined: both are tied to 0 and the counter logic is removed.
  - Ports are present either way.

## Structure
- Package irs_read_pkg holds:
  - event FSM and free FSM state enums;
  - DEPTH default;
  - block width constant (9).
- Sub-module irs_block_ring holds:
  - the DEPTH×10 slot memory (block + last flag);
  - the alloc/commit/rd/fr pointers and free-space computation.
- The top level holds both FSMs and pend.

## Test plan
- Basic event:
  - Stimulus: len=4; history responder returns blocks 100,99,98,97 for offsets 0..3; all acks 1 cycle after req.
  - Required response: locks requested 100,99,98,97; readout 97,98,99,100 with rd_last_o on 100.
- Full ring (DEPTH=16):
  - Stimulus: two len=8 events committed, none freed; third trigger.
  - Required response: third trigger dropped, dropped count=1, no hist_req_o.
- Free ordering:
  - Stimulus: read 3 blocks; rd_done_i ×3 back-to-back; free_ack_i delayed 5 cycles each.
  - Required response: free_req_o for the 3 blocks in read order, pend returns to 0.
- Illegal done:
  - Stimulus: rd_done_i with nothing read.
  - Required response: err_o=1 sticky, no free_req_o.
- Pointer wrap:
  - Stimulus: 40 len=3 events streamed with immediate readout and free.
  - Required response: correct block order throughout, counters 40/0.
- Reset mid-event:
  - Stimulus: rst_i while in LOCK with lock_req_o=1.
  - Required response: lock_req_o=0 next cycle; busy_o=0; rd_valid_o=0.
